instruction_decoder: RTL and testbench

- Multi-cycle decode/sequencing stage between instruction ROM and program counter.
- Latches the instruction word fetched at the current PC address and drives register-file/ALU control.
- Owns the Z/C flag register and evaluates conditional jumps.
- Tells the PC when to step or jump: one PC update per instruction, at the end of EXEC.

---
 rtl/decoder_pkg.sv | 77 +++++++
 rtl/instr_field_decode.sv | 47 ++++
 rtl/instruction_decoder.sv | 146 ++++++++++++++
 tb/tb_instruction_decoder.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types for the instruction decoder: opcodes, ALU operations, FSM states,
// instruction field positions and the decoded control bundle.
package decoder_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int OPC_MSB     = 15;
  localparam int OPC_LSB     = 12;
  localparam int RD_LSB      = 10;
  localparam int RS_LSB      = 8;
  localparam int IMM_MSB     = 7;

  typedef enum logic [3:0] {
    OPC_NOP   = 4'h0,
    OPC_LDI   = 4'h1,
    OPC_MOV   = 4'h2,
    OPC_ADD   = 4'h3,
    OPC_SUB   = 4'h4,
    OPC_AND   = 4'h5,
    OPC_OR    = 4'h6,
    OPC_XOR   = 4'h7,
    OPC_ADDI  = 4'h8,
    OPC_JMP   = 4'h9,
    OPC_JZ    = 4'hA,
    OPC_JNZ   = 4'hB,
    OPC_JC    = 4'hC,
    OPC_ILL_D = 4'hD,
    OPC_ILL_E = 4'hE,
    OPC_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_OR     = 3'd4,
    ALU_XOR    = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } dec_state_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_Z      = 2'd1,
    COND_NZ     = 2'd2,
    COND_C      = 2'd3
  } jump_cond_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       use_imm;
    logic       reg_we_req;
    logic       flag_we;
    logic       is_jump;
    jump_cond_e cond;
    logic       is_trap;
  } ctrl_t;

  // Jump condition against the flags stored before the current EXEC.
  function automatic logic cond_met(input jump_cond_e cond, input logic z, input logic c);
    logic met;
    case (cond)
      COND_ALWAYS: met = 1'b1;
      COND_Z:      met = z;
      COND_NZ:     met = ~z;
      COND_C:      met = c;
      default:     met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational opcode -> control bundle decode for the instruction decoder.
// With DECODER_ILLEGAL_TRAP_EN defined, opcodes D/E decode as traps instead of NOPs.
module instr_field_decode
  import decoder_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  opcode_e opc_s;
  assign opc_s = opcode_e'(opcode);

  // Opcode table: LDI/MOV write without touching flags; ALU ops also latch flags.
  always_comb begin
    ctrl            = '0;
    ctrl.alu_op     = ALU_PASS_B;
    ctrl.cond       = COND_ALWAYS;
    case (opc_s)
      OPC_NOP:  ctrl.alu_op = ALU_PASS_B;
      OPC_LDI:  begin ctrl.use_imm = 1'b1; ctrl.reg_we_req = 1'b1; end
      OPC_MOV:  ctrl.reg_we_req = 1'b1;
      OPC_ADD:  begin ctrl.alu_op = ALU_ADD; ctrl.reg_we_req = 1'b1; ctrl.flag_we = 1'b1; end
      OPC_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.reg_we_req = 1'b1; ctrl.flag_we = 1'b1; end
      OPC_AND:  begin ctrl.alu_op = ALU_AND; ctrl.reg_we_req = 1'b1; ctrl.flag_we = 1'b1; end
      OPC_OR:   begin ctrl.alu_op = ALU_OR;  ctrl.reg_we_req = 1'b1; ctrl.flag_we = 1'b1; end
      OPC_XOR:  begin ctrl.alu_op = ALU_XOR; ctrl.reg_we_req = 1'b1; ctrl.flag_we = 1'b1; end
      OPC_ADDI: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.use_imm    = 1'b1;
        ctrl.reg_we_req = 1'b1;
        ctrl.flag_we    = 1'b1;
      end
      OPC_JMP:  begin ctrl.is_jump = 1'b1; ctrl.cond = COND_ALWAYS; end
      OPC_JZ:   begin ctrl.is_jump = 1'b1; ctrl.cond = COND_Z; end
      OPC_JNZ:  begin ctrl.is_jump = 1'b1; ctrl.cond = COND_NZ; end
      OPC_JC:   begin ctrl.is_jump = 1'b1; ctrl.cond = COND_C; end
`ifdef DECODER_ILLEGAL_TRAP_EN
      OPC_ILL_D, OPC_ILL_E: ctrl.is_trap = 1'b1;
`else
      OPC_ILL_D, OPC_ILL_E: ctrl.is_trap = 1'b0;
`endif
      OPC_HALT: ctrl.is_trap = 1'b1;
      default:  ctrl.is_trap = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_decoder.sv
// FETCH/DECODE/EXEC sequencer between instruction ROM and PC; owns IR and Z/C flags.
// Optional macro DECODER_ILLEGAL_TRAP_EN: opcodes D/E halt and raise illegal_op.
module instruction_decoder
  import decoder_pkg::*;
#(
  parameter int BITS_FOR_INSTRUCTIONS = 5,
  parameter int DATA_WIDTH            = 8,
  parameter int REG_ADDR_BITS         = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INSTR_WIDTH-1:0]           instr_data,
  input  logic                             alu_zero,
  input  logic                             alu_carry,
  output logic                             pc_enable,
  output logic                             jump_enable,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] jump_value,
  output logic                             reg_we,
  output logic [REG_ADDR_BITS-1:0]         reg_waddr,
  output logic [REG_ADDR_BITS-1:0]         reg_raddr_a,
  output logic [REG_ADDR_BITS-1:0]         reg_raddr_b,
  output logic [2:0]                       alu_op,
  output logic                             use_imm,
  output logic [DATA_WIDTH-1:0]            imm,
  output logic                             flag_z,
  output logic                             flag_c,
  output logic                             halted
`ifdef DECODER_ILLEGAL_TRAP_EN
  ,
  output logic                             illegal_op
`endif
);

  dec_state_e               state_q, state_d;
  logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
  logic                     flag_z_q, flag_z_d;
  logic                     flag_c_q, flag_c_d;
  ctrl_t                    ctrl_s;
  logic                     taken_s;
  logic                     pc_enable_s;
  logic                     jump_enable_s;
  logic                     reg_we_s;
  logic [BITS_FOR_INSTRUCTIONS-1:0] jump_value_s;

  instr_field_decode u_field_decode (
    .opcode (ir_q[OPC_MSB:OPC_LSB]),
    .ctrl   (ctrl_s)
  );

  assign taken_s = ctrl_s.is_jump & cond_met(ctrl_s.cond, flag_z_q, flag_c_q);

  // Next-state, IR load, flag update and EXEC strobes.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    flag_z_d      = flag_z_q;
    flag_c_d      = flag_c_q;
    pc_enable_s   = 1'b0;
    jump_enable_s = 1'b0;
    reg_we_s      = 1'b0;
    jump_value_s  = '0;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = instr_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        reg_we_s = ctrl_s.reg_we_req;
        if (ctrl_s.is_trap) begin
          state_d = ST_HALT;
        end else begin
          pc_enable_s   = 1'b1;
          jump_enable_s = taken_s;
          state_d       = ST_FETCH;
        end
        jump_value_s = taken_s ? ir_q[BITS_FOR_INSTRUCTIONS-1:0] : '0;
        if (ctrl_s.flag_we) begin
          flag_z_d = alu_zero;
          flag_c_d = alu_carry;
        end else begin
          flag_z_d = flag_z_q;
          flag_c_d = flag_c_q;
        end
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // State, IR and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // Reset is sampled on the same edge as the strobes, so a reset during EXEC must mask them.
  assign pc_enable   = pc_enable_s & rst;
  assign jump_enable = jump_enable_s & rst;
  assign reg_we      = reg_we_s & rst;
  assign jump_value  = rst ? jump_value_s : '0;

  assign reg_waddr   = ir_q[RD_LSB +: REG_ADDR_BITS];
  assign reg_raddr_a = ir_q[RD_LSB +: REG_ADDR_BITS];
  assign reg_raddr_b = ir_q[RS_LSB +: REG_ADDR_BITS];
  assign alu_op      = ctrl_s.alu_op;
  assign use_imm     = ctrl_s.use_imm;
  assign imm         = ir_q[DATA_WIDTH-1:0];
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign halted      = (state_q == ST_HALT);

`ifdef DECODER_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if ((state_q == ST_EXEC) && ctrl_s.is_trap && (ir_q[OPC_MSB:OPC_LSB] != OPC_HALT)) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

  // Sticky illegal-opcode indicator, rises together with halted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench: directed scenarios plus random programs checked against an
// instruction-level model, with a behavioural ROM and PC around the decoder.
module tb_instruction_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr_data;
  logic        alu_zero = 1'b0;
  logic        alu_carry = 1'b0;
  logic        pc_enable, jump_enable, reg_we, use_imm, flag_z, flag_c, halted;
  logic [4:0]  jump_value;
  logic [1:0]  reg_waddr, reg_raddr_a, reg_raddr_b;
  logic [2:0]  alu_op;
  logic [7:0]  imm;
`ifdef DECODER_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  logic [15:0] rom [32];
  logic [4:0]  pc;
  int tests_run = 0;
  int tests_failed = 0;

  instruction_decoder dut (
    .clk(clk), .rst(rst), .instr_data(instr_data), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .pc_enable(pc_enable), .jump_enable(jump_enable), .jump_value(jump_value), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_raddr_a(reg_raddr_a), .reg_raddr_b(reg_raddr_b), .alu_op(alu_op),
    .use_imm(use_imm), .imm(imm), .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
`ifdef DECODER_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  // Environment: synchronous ROM and program counter driven by the decoder.
  always @(posedge clk) begin
    if (!rst) pc <= 5'd0;
    else if (pc_enable) pc <= jump_enable ? jump_value : pc + 5'd1;
    instr_data <= rom[pc];
  end

  function automatic logic [15:0] ins(input logic [3:0] o, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] im);
    return {o, rd, rs, im};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 32; a++) rom[a] = 16'h0000;
  endtask

  // Leaves the bench at a negedge inside the first FETCH cycle after reset.
  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_rom();
    alu_zero = 1'b1;
    alu_carry = 1'b1;
    do_reset();
    tests_run++;
    if ({halted, flag_z, flag_c} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_state halted/z/c=%b expected 000", {halted, flag_z, flag_c});
    end
    tests_run++;
    if ({reg_we, pc_enable, jump_enable, jump_value} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_strobes we/pce/je/jv=%b expected 0", {reg_we, pc_enable, jump_enable, jump_value});
    end
    tests_run++;
    if ({reg_waddr, alu_op, imm} !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_ir waddr/op/imm=%h expected 0", {reg_waddr, alu_op, imm});
    end
  endtask

  task automatic test_ldi_halt();
    clear_rom();
    rom[0] = ins(4'h1, 2'd1, 2'd0, 8'd5);
    rom[1] = ins(4'hF, 2'd0, 2'd0, 8'd0);
    do_reset();
    tick();
    tests_run++;
    if ({reg_we, pc_enable} !== 2'b00) begin
      tests_failed++;
      $display("FAIL ldi_decode_strobes got=%b expected 00", {reg_we, pc_enable});
    end
    tick();
    tests_run++;
    if ({reg_we, reg_waddr, imm, pc_enable, jump_enable, use_imm} !== {1'b1, 2'd1, 8'd5, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL ldi_exec got=%h expected %h", {reg_we, reg_waddr, imm, pc_enable, jump_enable, use_imm},
               {1'b1, 2'd1, 8'd5, 1'b1, 1'b0, 1'b1});
    end
    tick(); tick(); tick();
    tests_run++;
    if ({pc_enable, reg_we, halted} !== 3'b000) begin
      tests_failed++;
      $display("FAIL halt_exec pce/we/halted=%b expected 000", {pc_enable, reg_we, halted});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if ({halted, pc_enable, pc} !== {1'b1, 1'b0, 5'd1}) begin
        tests_failed++;
        $display("FAIL halt_hold cyc%0d halted/pce/pc=%b expected 1_0_00001", k, {halted, pc_enable, pc});
      end
    end
  endtask

  task automatic test_flags_jumps();
    clear_rom();
    rom[0]  = ins(4'h4, 2'd0, 2'd0, 8'd0);
    rom[1]  = ins(4'hA, 2'd0, 2'd0, 8'h1F);
    rom[31] = ins(4'h9, 2'd0, 2'd0, 8'h02);
    rom[2]  = ins(4'h3, 2'd1, 2'd2, 8'd0);
    rom[3]  = ins(4'hB, 2'd0, 2'd0, 8'h04);
    rom[4]  = ins(4'hC, 2'd0, 2'd0, 8'h07);
    rom[7]  = ins(4'hF, 2'd0, 2'd0, 8'd0);
    do_reset();
    alu_zero = 1'b1; alu_carry = 1'b0;
    tick(); tick();
    tests_run++;
    if ({reg_we, alu_op, pc_enable} !== {1'b1, 3'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL sub_exec we/op/pce=%b expected 1_010_1", {reg_we, alu_op, pc_enable});
    end
    tick();
    alu_zero = 1'b0; alu_carry = 1'b1;
    tests_run++;
    if ({flag_z, flag_c} !== 2'b10) begin
      tests_failed++;
      $display("FAIL sub_flags zc=%b expected 10", {flag_z, flag_c});
    end
    tick(); tick();
    tests_run++;
    if ({jump_enable, pc_enable, jump_value, reg_we} !== {1'b1, 1'b1, 5'd31, 1'b0}) begin
      tests_failed++;
      $display("FAIL jz_taken je/pce/jv/we=%b expected 1_1_11111_0", {jump_enable, pc_enable, jump_value, reg_we});
    end
    tick(); tick(); tick();
    tests_run++;
    if ({jump_enable, jump_value, flag_z, flag_c} !== {1'b1, 5'd2, 2'b10}) begin
      tests_failed++;
      $display("FAIL jmp_taken je/jv/zc=%b expected 1_00010_10", {jump_enable, jump_value, flag_z, flag_c});
    end
    tick(); tick(); tick();
    tests_run++;
    if ({reg_we, alu_op, reg_waddr, reg_raddr_b} !== {1'b1, 3'd1, 2'd1, 2'd2}) begin
      tests_failed++;
      $display("FAIL add_exec we/op/wa/rb=%b expected 1_001_01_10", {reg_we, alu_op, reg_waddr, reg_raddr_b});
    end
    tick();
    alu_zero = 1'b1; alu_carry = 1'b0;
    tests_run++;
    if ({flag_z, flag_c} !== 2'b01) begin
      tests_failed++;
      $display("FAIL add_flags zc=%b expected 01", {flag_z, flag_c});
    end
    tick(); tick();
    tests_run++;
    if ({jump_enable, pc_enable, jump_value} !== {1'b1, 1'b1, 5'd4}) begin
      tests_failed++;
      $display("FAIL jnz_taken je/pce/jv=%b expected 1_1_00100", {jump_enable, pc_enable, jump_value});
    end
    tick(); tick(); tick();
    tests_run++;
    if ({jump_enable, pc_enable, jump_value, flag_z, flag_c} !== {1'b1, 1'b1, 5'd7, 2'b01}) begin
      tests_failed++;
      $display("FAIL jc_taken je/pce/jv/zc=%b expected 1_1_00111_01", {jump_enable, pc_enable, jump_value, flag_z, flag_c});
    end
  endtask

  task automatic test_ldi_mov();
    clear_rom();
    rom[0] = ins(4'h4, 2'd0, 2'd0, 8'd0);
    rom[1] = ins(4'h1, 2'd3, 2'd0, 8'hAA);
    rom[2] = ins(4'h2, 2'd2, 2'd3, 8'h00);
    do_reset();
    alu_zero = 1'b1; alu_carry = 1'b0;
    tick(); tick(); tick();
    alu_zero = 1'b0; alu_carry = 1'b1;
    tick(); tick(); tick();
    tests_run++;
    if ({flag_z, flag_c} !== 2'b10) begin
      tests_failed++;
      $display("FAIL ldi_keeps_flags zc=%b expected 10", {flag_z, flag_c});
    end
    tick(); tick();
    tests_run++;
    if ({reg_raddr_b, reg_waddr, reg_raddr_a, reg_we, use_imm, alu_op} !== {2'd3, 2'd2, 2'd2, 1'b1, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL mov_exec rb/wa/ra/we/ui/op=%b expected 11_10_10_1_0_000",
               {reg_raddr_b, reg_waddr, reg_raddr_a, reg_we, use_imm, alu_op});
    end
  endtask

  task automatic test_reset_mid_exec();
    clear_rom();
    rom[0] = ins(4'h3, 2'd1, 2'd2, 8'd0);
    do_reset();
    alu_zero = 1'b1; alu_carry = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({reg_we, pc_enable, jump_enable} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_in_exec we/pce/je=%b expected 000", {reg_we, pc_enable, jump_enable});
    end
    tick();
    tests_run++;
    if ({flag_z, flag_c, halted} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_after_exec zc/halted=%b expected 000", {flag_z, flag_c, halted});
    end
    rst = 1'b1;
    tick(); tick();
    tests_run++;
    if ({reg_we, pc_enable} !== 2'b11) begin
      tests_failed++;
      $display("FAIL rst_restart_fetch we/pce=%b expected 11", {reg_we, pc_enable});
    end
  endtask

  task automatic test_illegal();
    clear_rom();
    rom[0] = ins(4'hD, 2'd1, 2'd1, 8'd3);
    rom[1] = ins(4'h1, 2'd1, 2'd0, 8'd9);
    do_reset();
    tick(); tick();
`ifdef DECODER_ILLEGAL_TRAP_EN
    tests_run++;
    if ({pc_enable, reg_we} !== 2'b00) begin
      tests_failed++;
      $display("FAIL illegal_trap_exec pce/we=%b expected 00", {pc_enable, reg_we});
    end
    tick();
    tests_run++;
    if ({halted, illegal_op} !== 2'b11) begin
      tests_failed++;
      $display("FAIL illegal_trap_halt halted/ill=%b expected 11", {halted, illegal_op});
    end
`else
    tests_run++;
    if ({pc_enable, jump_enable, reg_we} !== 3'b100) begin
      tests_failed++;
      $display("FAIL illegal_nop_exec pce/je/we=%b expected 100", {pc_enable, jump_enable, reg_we});
    end
    tick(); tick(); tick();
    tests_run++;
    if ({halted, reg_we, imm} !== {1'b0, 1'b1, 8'd9}) begin
      tests_failed++;
      $display("FAIL illegal_nop_next halted/we/imm=%h expected 109", {halted, reg_we, imm});
    end
`endif
  endtask

  function automatic logic [15:0] rand_instr();
    int r;
    logic [3:0] o;
    r = $urandom_range(0, 99);
    if (r < 2) o = 4'hF;
    else if (r < 6) o = (r < 4) ? 4'hD : 4'hE;
    else o = 4'($urandom_range(0, 12));
    return {o, 12'($urandom())};
  endfunction

  // Random programs against an instruction-level model of the decoder + PC.
  task automatic test_random();
    logic [15:0] w;
    logic [3:0]  o;
    logic [4:0]  pc_m;
    logic        z_m, c_m, halt_m, ill_m, az, ac, taken, trap, is_alu;
    logic [2:0]  exp_op;
    logic [25:0] got, exp;
    for (int p = 0; p < 6; p++) begin
      for (int a = 0; a < 32; a++) rom[a] = rand_instr();
      do_reset();
      pc_m = 5'd0; z_m = 1'b0; c_m = 1'b0; halt_m = 1'b0; ill_m = 1'b0;
      for (int k = 0; k < 80; k++) begin
        if (halt_m) begin
          tests_run++;
          if ({halted, pc_enable, reg_we, pc} !== {1'b1, 1'b0, 1'b0, pc_m}) begin
            tests_failed++;
            $display("FAIL rand_halted p%0d halted/pce/we/pc=%b expected 1_0_0_%b", p, {halted, pc_enable, reg_we, pc}, pc_m);
          end
`ifdef DECODER_ILLEGAL_TRAP_EN
          tests_run++;
          if (illegal_op !== ill_m) begin
            tests_failed++;
            $display("FAIL rand_illegal p%0d got=%b expected %b", p, illegal_op, ill_m);
          end
`endif
          tick();
          continue;
        end
        w = rom[pc_m];
        o = w[15:12];
        az = ($urandom() & 32'd1) != 0;
        ac = ($urandom() & 32'd1) != 0;
        alu_zero = az; alu_carry = ac;
        tests_run++;
        if ({pc, flag_z, flag_c, halted, reg_we, pc_enable, jump_enable} !== {pc_m, z_m, c_m, 4'b0000}) begin
          tests_failed++;
          $display("FAIL rand_fetch p%0d k%0d got=%b expected %b", p, k,
                   {pc, flag_z, flag_c, halted, reg_we, pc_enable, jump_enable}, {pc_m, z_m, c_m, 4'b0000});
        end
        tick();
        tick();
        is_alu = (o >= 4'h3) && (o <= 4'h8);
        case (o)
          4'h3, 4'h8: exp_op = 3'd1;
          4'h4: exp_op = 3'd2;
          4'h5: exp_op = 3'd3;
          4'h6: exp_op = 3'd4;
          4'h7: exp_op = 3'd5;
          default: exp_op = 3'd0;
        endcase
        case (o)
          4'h9: taken = 1'b1;
          4'hA: taken = z_m;
          4'hB: taken = !z_m;
          4'hC: taken = c_m;
          default: taken = 1'b0;
        endcase
`ifdef DECODER_ILLEGAL_TRAP_EN
        trap = (o == 4'hF) || (o == 4'hD) || (o == 4'hE);
`else
        trap = (o == 4'hF);
`endif
        exp = {(o >= 4'h1) && (o <= 4'h8), w[11:10], w[11:10], w[9:8], exp_op,
               (o == 4'h1) || (o == 4'h8), w[7:0], !trap, taken, taken ? w[4:0] : 5'd0};
        got = {reg_we, reg_waddr, reg_raddr_a, reg_raddr_b, alu_op, use_imm, imm, pc_enable, jump_enable, jump_value};
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL rand_exec p%0d k%0d instr=%h got=%h expected %h", p, k, w, got, exp);
        end
        if (is_alu) begin z_m = az; c_m = ac; end
        if (trap) begin
          halt_m = 1'b1;
          ill_m = (o != 4'hF);
        end else begin
          pc_m = taken ? w[4:0] : pc_m + 5'd1;
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi_halt();
    test_flags_jumps();
    test_ldi_mov();
    test_reset_mid_exec();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
